pe_typed_issue: RTL and testbench

Operand-issue and result-collection stage directly upstream of the CGRA type-D processing element (PE_typeD). It joins two independent valid/ready 64-bit operand streams into a single issue, registers operands and opcode onto the PE's free-running inputs, and tracks every issue through the PE's fixed, non-stallable pipeline. Results are captured into a local FIFO behind a valid/ready port. Credit accounting ensures no PE result is ever dropped under downstream backpressure.

---
 rtl/pe_typed_pkg.sv | 8 +
 rtl/pe_result_fifo.sv | 57 +++++
 rtl/pe_typed_issue.sv | 112 +++++++++++
 tb/tb_pe_typed_issue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_typed_pkg.sv
// Shared types for the PE type-D operand-issue stage.
package pe_typed_pkg;
  localparam int DATA_W = 64;

  typedef logic [1:0] op_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} issue_state_t;
endpackage

// File: rtl/pe_result_fifo.sv
// Result FIFO behind the PE; count-based full/empty, storage reset so read data is 0 after reset.
module pe_result_fifo #(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [DATA_W-1:0]              rd_data,
  output logic [$clog2(OUT_DEPTH+1)-1:0] count,
  output logic                           empty
);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH+1);

  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [DATA_W-1:0] mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, do_push, do_pop;

  always_comb begin
    full     = count_q == CNT_W'(OUT_DEPTH);
    empty    = count_q == '0;
    // upstream credit makes a push into a full FIFO unreachable; the guard keeps storage sane regardless
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/pe_typed_issue.sv
// Joins operand streams A/B into the PE, tracks issues through its fixed pipeline
// with a tag shift register, and collects results under credit control.
module pe_typed_issue
  import pe_typed_pkg::*;
#(
  parameter int PE_LAT    = 8,
  parameter int OUT_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              a_data,
  input  op_t                            a_op,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [DATA_W-1:0]              b_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  output logic [DATA_W-1:0]              pe_inp1,
  output logic [DATA_W-1:0]              pe_inp2,
  output op_t                            pe_op,
  input  logic [DATA_W-1:0]              pe_out1,
  output logic [DATA_W-1:0]              res_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic [$clog2(OUT_DEPTH+1)-1:0] inflight
);
  localparam int CNT_W = $clog2(OUT_DEPTH+1);

  issue_state_t      state_q, state_d;
  logic [DATA_W-1:0] pe_inp1_q, pe_inp1_d, pe_inp2_q, pe_inp2_d;
  op_t               pe_op_q, pe_op_d;
  logic [PE_LAT-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              fifo_empty, can_issue, fire, push, pop;

  always_comb begin
    // every issue owns a FIFO slot from fire until pop, so the PE can never overrun the FIFO
    occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
    can_issue  = (state_q == RUN) && !flush_req && (occupancy < (CNT_W+1)'(OUT_DEPTH));
    a_ready    = b_valid && can_issue;
    b_ready    = a_valid && can_issue;
    fire       = a_valid && b_valid && can_issue;
    push       = tag_q[PE_LAT-1];
    pop        = res_valid && res_ready;
    tag_d      = (tag_q << 1) | PE_LAT'(fire);
    inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(push);
    pe_inp1_d  = pe_inp1_q;
    pe_inp2_d  = pe_inp2_q;
    pe_op_d    = pe_op_q;
    if (fire) begin
      pe_inp1_d = a_data;
      pe_inp2_d = b_data;
      pe_op_d   = a_op;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && fifo_empty) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pe_inp1_q  <= '0;
      pe_inp2_q  <= '0;
      pe_op_q    <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      pe_inp1_q  <= pe_inp1_d;
      pe_inp2_q  <= pe_inp2_d;
      pe_op_q    <= pe_op_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  pe_result_fifo #(
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (pe_out1),
    .pop       (pop),
    .rd_data   (res_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign res_valid = !fifo_empty;
  assign pe_inp1   = pe_inp1_q;
  assign pe_inp2   = pe_inp2_q;
  assign pe_op     = pe_op_q;
  assign inflight  = inflight_q;
endmodule

// File: tb/tb_pe_typed_issue.sv
// Directed bench for pe_typed_issue with an XOR stub PE and an in-order result scoreboard.
module tb_pe_typed_issue;
  import pe_typed_pkg::*;

  localparam int PE_LAT    = 8;
  localparam int OUT_DEPTH = 16;
  localparam int CNT_W     = $clog2(OUT_DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] a_data, b_data, pe_inp1, pe_inp2, pe_out1, res_data;
  op_t               a_op, pe_op;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic              res_valid, res_ready, flush_req, flush_done;
  logic [CNT_W-1:0]  inflight;

  int checks = 0, errors = 0;
  int fires = 0, pops = 0, cyc = 0;
  int first_fire_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1, max_infl = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  always #5 clk = ~clk;

  pe_typed_issue #(.PE_LAT(PE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_op(a_op), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .pe_inp1(pe_inp1), .pe_inp2(pe_inp2), .pe_op(pe_op), .pe_out1(pe_out1),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .flush_req(flush_req), .flush_done(flush_done), .inflight(inflight)
  );

  // Stub PE: the DUT's pe_* registers are its load stage, followed by PE_LAT-1 stages of inp1^inp2.
  logic [DATA_W-1:0] pe_pipe [PE_LAT-1];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PE_LAT-1; i++) pe_pipe[i] <= '0;
    end else begin
      pe_pipe[0] <= pe_inp1 ^ pe_inp2;
      for (int i = 1; i < PE_LAT-1; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
  end
  assign pe_out1 = pe_pipe[PE_LAT-2];

  always @(posedge clk) cyc++;

  // Transfers are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready && b_valid && b_ready) begin
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        exp_q.push_back(a_data ^ b_data);
        fires++;
      end
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL result_unexpected got %h required none", res_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (res_data !== exp_v) begin
            errors++; $display("FAIL result_order got %h required %h", res_data, exp_v);
          end
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
      if (int'(inflight) > max_infl) max_infl = int'(inflight);
      assert (!(dut.u_fifo.push && dut.u_fifo.full)) else begin
        errors++; $display("FAIL fifo_overflow got push while full required no push");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_pair(input int i);
    a_data = 64'h4010_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0001;
    b_data = 64'h3FF0_0000_0000_0000 ^ (64'(i) << 12);
    a_op   = op_t'(i % 4);
  endtask

  // Offers pairs base.. until n have fired or the cycle budget runs out.
  task automatic stream(input int n, input int base, input int budget);
    int f0, k;
    f0 = fires; k = 0;
    while ((fires - f0) < n && k < budget) begin
      drive_pair(base + fires - f0);
      a_valid = 1'b1; b_valid = 1'b1;
      step(); k++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 0; b_valid = 0; res_ready = 0; flush_req = 0;
    a_data = '0; b_data = '0; a_op = '0;
    step(); step();
    checks++; if (pe_inp1 !== '0) begin errors++; $display("FAIL reset_pe_inp1 got %h required 0", pe_inp1); end
    checks++; if (pe_inp2 !== '0) begin errors++; $display("FAIL reset_pe_inp2 got %h required 0", pe_inp2); end
    checks++; if (pe_op !== 2'b00) begin errors++; $display("FAIL reset_pe_op got %b required 00", pe_op); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b required 0", res_valid); end
    checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got %h required 0", res_data); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b required 00", {a_ready, b_ready}); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b required 0", flush_done); end
    checks++; if (inflight !== '0) begin errors++; $display("FAIL reset_inflight got %0d required 0", inflight); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_issue();
    int f0;
    logic early;
    res_ready = 0;
    a_data = 64'h4020_0000_0000_0000; b_data = 64'h4000_0000_0000_0000; a_op = 2'b10;
    a_valid = 1; b_valid = 1; #1;
    checks++; if ({a_ready, b_ready} !== 2'b11) begin errors++; $display("FAIL single_ready got %b required 11", {a_ready, b_ready}); end
    f0 = fires;
    step();
    a_valid = 0; b_valid = 0;
    checks++; if (fires != f0 + 1) begin errors++; $display("FAIL single_fire got %0d required 1", fires - f0); end
    checks++; if (pe_inp1 !== 64'h4020_0000_0000_0000) begin errors++; $display("FAIL single_pe_inp1 got %h required 4020000000000000", pe_inp1); end
    checks++; if (pe_inp2 !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL single_pe_inp2 got %h required 4000000000000000", pe_inp2); end
    checks++; if (pe_op !== 2'b10) begin errors++; $display("FAIL single_pe_op got %b required 10", pe_op); end
    early = res_valid;
    for (int k = 1; k < PE_LAT; k++) begin
      step();
      if (res_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL single_early_valid got 1 required 0 before %0d cycles", PE_LAT+1); end
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b required 1", res_valid); end
    checks++; if (res_data !== 64'h0020_0000_0000_0000) begin errors++; $display("FAIL single_res_data got %h required 0020000000000000", res_data); end
    res_ready = 1;
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %b required 0", res_valid); end
  endtask

  task automatic test_join();
    int f0;
    logic bad;
    res_ready = 1; bad = 0;
    drive_pair(500);
    a_valid = 1; b_valid = 0;
    f0 = fires;
    for (int k = 0; k < 5; k++) begin
      #1; if (a_ready !== 1'b0) bad = 1'b1;
      step();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL join_a_ready got 1 required 0"); end
    checks++; if (fires != f0) begin errors++; $display("FAIL join_early_fire got %0d required 0", fires - f0); end
    b_valid = 1; #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL join_a_ready_when_b got %b required 1", a_ready); end
    step();
    a_valid = 0; b_valid = 0;
    checks++; if (fires != f0 + 1) begin errors++; $display("FAIL join_fire got %0d required 1", fires - f0); end
    repeat (PE_LAT + 3) step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL join_drain got %0d required 0 pending", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int f0, p0, k;
    res_ready = 0; f0 = fires; p0 = pops; max_infl = 0;
    stream(40, 1000, 60);
    checks++; if (fires - f0 != OUT_DEPTH) begin errors++; $display("FAIL bp_fires got %0d required %0d", fires - f0, OUT_DEPTH); end
    drive_pair(1000 + OUT_DEPTH); a_valid = 1; b_valid = 1; #1;
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready got %b required 00", {a_ready, b_ready}); end
    a_valid = 0; b_valid = 0;
    res_ready = 1;
    stream(40 - (fires - f0), 1000 + (fires - f0), 200);
    k = 0;
    while (pops - p0 < 40 && k < 100) begin step(); k++; end
    checks++; if (pops - p0 != 40) begin errors++; $display("FAIL bp_results got %0d required 40", pops - p0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending got %0d required 0", exp_q.size()); end
    checks++; if (max_infl > OUT_DEPTH) begin errors++; $display("FAIL bp_inflight got %0d required <= %0d", max_infl, OUT_DEPTH); end
  endtask

  task automatic test_full_rate();
    int f0, p0, c0;
    res_ready = 1; f0 = fires; p0 = pops; max_infl = 0;
    first_fire_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    c0 = cyc;
    stream(100, 2000, 110);
    checks++; if (cyc - c0 != 100) begin errors++; $display("FAIL full_issue_cycles got %0d required 100", cyc - c0); end
    repeat (PE_LAT + 4) step();
    checks++; if (pops - p0 != 100) begin errors++; $display("FAIL full_results got %0d required 100", pops - p0); end
    checks++; if (last_pop_cyc - first_pop_cyc != 99) begin errors++; $display("FAIL full_consecutive got %0d required 99", last_pop_cyc - first_pop_cyc); end
    checks++; if (first_pop_cyc - first_fire_cyc != PE_LAT + 1) begin errors++; $display("FAIL full_latency got %0d required %0d", first_pop_cyc - first_fire_cyc, PE_LAT + 1); end
    checks++; if (max_infl != PE_LAT) begin errors++; $display("FAIL full_inflight got %0d required %0d", max_infl, PE_LAT); end
  endtask

  task automatic test_flush();
    int f0, p0;
    logic got;
    res_ready = 1; f0 = fires; p0 = pops; got = 0;
    stream(5, 3000, 10);
    drive_pair(3005); a_valid = 1; b_valid = 1; flush_req = 1; #1;
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL flush_ready got %b required 00", {a_ready, b_ready}); end
    checks++; if (inflight !== 5'd5) begin errors++; $display("FAIL flush_inflight got %0d required 5", inflight); end
    for (int k = 0; k < 60 && !got; k++) begin
      step();
      if (flush_done === 1'b1) got = 1'b1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL flush_done_seen got 0 required 1"); end
    checks++; if (fires - f0 != 5) begin errors++; $display("FAIL flush_fires got %0d required 5", fires - f0); end
    checks++; if (pops - p0 != 5) begin errors++; $display("FAIL flush_results got %0d required 5", pops - p0); end
    checks++; if (res_valid !== 1'b0 || inflight !== '0) begin errors++; $display("FAIL flush_empty got valid %b inflight %0d required 0 0", res_valid, inflight); end
    flush_req = 0;
    step();
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_pulse got %b required 0", flush_done); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL flush_resume got %b required 1", a_ready); end
    a_valid = 0; b_valid = 0;
    step();
  endtask

  task automatic test_reset_mid();
    int p0;
    res_ready = 0;
    stream(9, 4000, 20);
    step(); step();
    checks++; if (inflight !== 5'd6) begin errors++; $display("FAIL mid_inflight got %0d required 6", inflight); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_queued got %b required 1", res_valid); end
    #2 rst = 1; #1;
    checks++; if (inflight !== '0 || res_valid !== 1'b0) begin errors++; $display("FAIL mid_async_flags got inflight %0d valid %b required 0 0", inflight, res_valid); end
    checks++; if (res_data !== '0) begin errors++; $display("FAIL mid_async_res_data got %h required 0", res_data); end
    checks++; if (pe_inp1 !== '0 || pe_inp2 !== '0 || pe_op !== 2'b00) begin errors++; $display("FAIL mid_async_pe got %h %h %b required 0", pe_inp1, pe_inp2, pe_op); end
    exp_q.delete();
    step();
    rst = 0; res_ready = 1; p0 = pops;
    repeat (PE_LAT + 6) step();
    checks++; if (pops != p0) begin errors++; $display("FAIL mid_stale got %0d results required 0", pops - p0); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got %b required 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_join();
    test_backpressure();
    test_full_rate();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
